demux1x4_behav: RTL
===================

# demux1x4_behav

Lane-distribution receive block: the counterpart of the 4:1 byte multiplexer in the physical-layer datapath. It accepts one time-division-multiplexed byte stream per clock, rebuilds the four byte lanes (0..3), and presents them with per-lane valid bits once every four clocks. Frame alignment is free-running from reset and can be re-established with an explicit `sync` input.

## Interface
- `WIDTH`, 8, lane/byte width in bits.
- `clk`  in  1  root clock; one TDM slot per rising edge; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the `clk` rising edge.
- `in`  in  WIDTH  serial TDM byte for the current slot.
- `valid_in`  in  1  the byte in the current slot is valid.
- `sync`  in  1  the current byte is lane 0; forces frame realignment.
- `out0`..`out3`  out  WIDTH each  reconstructed lanes 0..3.
- `valid_out`  out  4  bit k qualifies `outk`.
- `out_stb`  out  1  one-cycle pulse: a new lane group was loaded this cycle.

## Operation
- `slot` is a 2-bit counter, 0..3, wrapping 3 -> 0. It advances by 1 on every non-reset clock, independent of `valid_in`.
- The effective slot for the current cycle is `eslot`:
  - `eslot = 0` if `sync` = 1.
  - Otherwise `eslot = slot`.
  - Next `slot = eslot + 1`, mod 4.
- Staging registers `stage0`..`stage2` (WIDTH each) and `sval[2:0]` hold lanes 0-2 of the frame being assembled.
- Capture when `eslot` = k, for k in 0..2:
  - `stagek <= in`
  - `sval[k] <= valid_in`
- Frame close when `eslot` = 3:
  - `out0..out2 <= stage0..stage2`, each forced to 0 where `sval[k]` = 0.
  - `out3 <= in` if `valid_in` = 1, else 0.
  - `valid_out <= {valid_in, sval[2:0]}`.
  - `out_stb <= 1`.
- All other cycles: `out0..out3` and `valid_out` hold; `out_stb <= 0`.
- Realignment, i.e. `sync` = 1 while `slot` != 0:
  - The partially assembled frame is discarded: `sval[2:0] <= 0`, then bit 0 is set from `valid_in`.
  - No strobe is generated for the discarded frame.
  - Outputs keep the last completed group.
- `sync` = 1 while `slot` = 0: no effect beyond normal operation.
- Invalid lane data is never exposed. An `outk` whose `valid_out[k]` = 0 always reads 0.

## Timing
- Reset values:
  - `slot` = 0, `stage0..2` = 0, `sval` = 0.
  - `out0..out3` = 0, `valid_out` = 4'b0000, `out_stb` = 0.
- The first non-reset cycle is slot 0.
- Latency from byte sampled to appearing on its `outk` (outputs change on the frame-close edge):
  - Lane 0: 4 clocks.
  - Lane 1: 3 clocks.
  - Lane 2: 2 clocks.
  - Lane 3: 1 clock.
- `out_stb` period is 4 clocks in steady state. Its first assertion is visible after the 4th non-reset edge.
- `sync` is sampled on the same edge as `in`. Following `sync`, the first `out_stb` comes exactly 4 edges after the `sync` edge.
- Reset mid-frame: the staged data is lost, the outputs clear on that edge, and there is no strobe.
- Reset takes priority over `sync` and over frame close when both occur on the same edge.
- `sync` on an `eslot` = 3 cycle (slot 3) is treated as slot 0. That frame is not closed, and no `out_stb` is issued.

## Test plan
- Reset check: hold `reset` = 1 for 3 clocks with `in` = 8'hFF and `valid_in` = 1.
  - Required: all outputs 0 and `out_stb` = 0 throughout.
- Steady stream: release reset, then drive `in` = A0, A1, A2, A3, B0, B1, … with `valid_in` = 1.
  - After the 4th edge: `out0..3` = A0, A1, A2, A3; `valid_out` = 4'hF; `out_stb` = 1 for one cycle.
  - 4 clocks later: B0..B3.
- Per-lane invalid: frame 11, 22, 33, 44 with `valid_in` = 1, 0, 1, 0.
  - Required: `out0..3` = 11, 00, 33, 00; `valid_out` = 4'b0101.
- Realignment: after a full group, drive two bytes C0, C1, then `sync` = 1 with D0, followed by D1, D2, D3.
  - Required: C0/C1 never appear and no strobe fires for them.
  - Next `out_stb` presents D0..D3 exactly 4 edges after the `sync` edge.
- Reset mid-frame: assert `reset` after 2 bytes of a frame, release it, then send E0..E3.
  - Required: outputs 0 during reset; next group = E0..E3 with `valid_out` = 4'hF.
- Hold behaviour: between strobes, drive random `in`.
  - Required: `out0..3` and `valid_out` stay unchanged; `out_stb` = 0.

Source files
------------

// File: rtl/demux1x4_behav.sv
// Receive-side 1:4 lane demultiplexer: rebuilds four byte lanes from a TDM stream
// and presents each completed group with per-lane valids and a one-cycle strobe.
module demux1x4_behav #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             valid_in,
    input  logic             sync,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [3:0]       valid_out,
    output logic             out_stb
);

    logic [1:0]       slot;
    logic [1:0]       eslot;
    logic             realign;
    logic [WIDTH-1:0] stage0;
    logic [WIDTH-1:0] stage1;
    logic [WIDTH-1:0] stage2;
    logic [2:0]       sval;

    // sync forces the current byte to lane 0; a sync off slot 0 abandons the partial frame
    always_comb begin
        eslot   = slot;
        realign = 1'b0;
        if (sync) begin
            eslot   = 2'd0;
            realign = (slot != 2'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot      <= 2'd0;
            stage0    <= '0;
            stage1    <= '0;
            stage2    <= '0;
            sval      <= 3'b000;
            out0      <= '0;
            out1      <= '0;
            out2      <= '0;
            out3      <= '0;
            valid_out <= 4'b0000;
            out_stb   <= 1'b0;
        end else begin
            slot    <= eslot + 2'd1;
            out_stb <= 1'b0;
            case (eslot)
                2'd0: begin
                    stage0 <= in;
                    if (realign) begin
                        sval <= {2'b00, valid_in};
                    end else begin
                        sval[0] <= valid_in;
                    end
                end
                2'd1: begin
                    stage1  <= in;
                    sval[1] <= valid_in;
                end
                2'd2: begin
                    stage2  <= in;
                    sval[2] <= valid_in;
                end
                default: begin
                    // Lanes flagged invalid are zeroed so stale staging data never leaks out
                    out0      <= sval[0] ? stage0 : '0;
                    out1      <= sval[1] ? stage1 : '0;
                    out2      <= sval[2] ? stage2 : '0;
                    out3      <= valid_in ? in : '0;
                    valid_out <= {valid_in, sval};
                    out_stb   <= 1'b1;
                end
            endcase
        end
    end

endmodule
